// File: rtl/crypto1_extend_filter.sv
// Extends 20-bit candidates by one bit and keeps the extensions whose nonlinear
// filter output reproduces the latched keystream bit. Survivors are streamed out.
module crypto1_extend_filter #(
  parameter logic [15:0] FA = 16'h9E98,
  parameter logic [15:0] FB = 16'hB48E,
  parameter logic [31:0] FC = 32'hEC57E80A
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        stb_i,
  input  logic        ks_bit_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [19:0] in_key_i,
  input  logic        in_last_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [20:0] out_key_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [16:0] count_o
);

  // state | meaning
  // IDLE  | waiting for stb_i; count_o holds last result
  // RUN   | accepting the next candidate
  // T0/T1 | testing extension bit 0 / 1
  // W0/W1 | survivor with extension bit 0 / 1 presented, waiting for sink
  // FIN   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_T0, S_W0, S_T1, S_W1, S_FIN
  } state_e;

  localparam logic [16:0] COUNT_MAX = 17'h10000;

  state_e      state_q, state_d;
  logic        ks_q, ks_d;
  logic        last_q, last_d;
  logic [19:0] key_q, key_d;
  logic [20:0] out_key_q, out_key_d;
  logic [16:0] count_q, count_d;
  logic        pass0, pass1;

  // The filter reads its 20 taps in the enumerator's bit-reversed order.
  function automatic logic filt(input logic [19:0] w);
    logic [19:0] r;
    logic [4:0]  c;
    for (int i = 0; i < 20; i++) r[i] = w[19-i];
    c = {FA[r[19:16]], FB[r[15:12]], FA[r[11:8]], FA[r[7:4]], FB[r[3:0]]};
    return FC[c];
  endfunction

  assign pass0 = (filt({1'b0, key_q[19:1]}) == ks_q);
  assign pass1 = (filt({1'b1, key_q[19:1]}) == ks_q);

  always_ff @(posedge clk_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (stb_i) state_d = S_RUN;
      S_RUN:  if (in_valid_i) state_d = S_T0;
      S_T0:   state_d = pass0 ? S_W0 : S_T1;
      S_W0:   if (out_ready_i) state_d = S_T1;
      S_T1: begin
        if (pass1)       state_d = S_W1;
        else if (last_q) state_d = S_FIN;
        else             state_d = S_RUN;
      end
      S_W1:   if (out_ready_i) state_d = last_q ? S_FIN : S_RUN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_RUN);
    out_valid_o = (state_q == S_W0) || (state_q == S_W1);
    busy_o      = (state_q != S_IDLE) && (state_q != S_FIN);
    done_o      = (state_q == S_FIN);
    out_key_o   = out_key_q;
    count_o     = count_q;
  end

  always_comb begin
    ks_d      = ks_q;
    last_d    = last_q;
    key_d     = key_q;
    out_key_d = out_key_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE: if (stb_i) begin
        ks_d    = ks_bit_i;
        count_d = '0;
      end
      S_RUN: if (in_valid_i) begin
        key_d  = in_key_i;
        last_d = in_last_i;
      end
      S_T0: if (pass0) out_key_d = {1'b0, key_q};
      S_T1: if (pass1) out_key_d = {1'b1, key_q};
      default: ;
    endcase
    // Saturates at 65536 rather than wrapping.
    if (out_valid_o && out_ready_i && (count_q != COUNT_MAX))
      count_d = count_q + 17'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      ks_q      <= 1'b0;
      last_q    <= 1'b0;
      key_q     <= '0;
      out_key_q <= '0;
      count_q   <= '0;
    end else begin
      ks_q      <= ks_d;
      last_q    <= last_d;
      key_q     <= key_d;
      out_key_q <= out_key_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_crypto1_extend_filter.sv
// Randomized bench for crypto1_extend_filter against an arithmetic model of the
// filter and a queue of expected survivors.
module tb_crypto1_extend_filter;

  localparam longint FA_T = 64'h9E98;
  localparam longint FB_T = 64'hB48E;
  localparam longint FC_T = 64'hEC57E80A;

  logic        clk_i = 0;
  logic        resetn_i = 0;
  logic        stb_i = 0;
  logic        ks_bit_i = 0;
  logic        in_valid_i = 0;
  logic        in_ready_o;
  logic [19:0] in_key_i = '0;
  logic        in_last_i = 0;
  logic        out_valid_o;
  logic        out_ready_i = 0;
  logic [20:0] out_key_o;
  logic        busy_o;
  logic        done_o;
  logic [16:0] count_o;

  int n_vec = 0;
  int n_err = 0;
  int cand[$];

  crypto1_extend_filter dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .stb_i(stb_i), .ks_bit_i(ks_bit_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_key_i(in_key_i),
    .in_last_i(in_last_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_key_o(out_key_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tbit(input longint t, input int n);
    return int'((t >> n) & 64'd1);
  endfunction

  function automatic int ref_f(input int w);
    int r = 0;
    int c;
    for (int i = 0; i < 20; i++)
      if (((w >> i) & 1) != 0) r = r | (1 << (19 - i));
    c = 16 * tbit(FA_T, (r >> 16) & 15) + 8 * tbit(FB_T, (r >> 12) & 15)
      + 4 * tbit(FA_T, (r >> 8) & 15) + 2 * tbit(FA_T, (r >> 4) & 15)
      + tbit(FB_T, r & 15);
    return tbit(FC_T, c);
  endfunction

  function automatic bit survives(input int k, input int e, input bit ks);
    int x = (e << 20) | k;
    return ref_f(x >> 1) == int'(ks);
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, in_ready_o, 0);
    check_eq({tag, "_out_valid"}, out_valid_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
    check_eq({tag, "_done"}, done_o, 0);
    check_eq({tag, "_count"}, count_o, 0);
    check_eq({tag, "_out_key"}, out_key_o, 0);
  endtask

  // bp: 0 random out_ready, 1 always ready, 2 five stalled cycles then ready
  task automatic run_case(input bit ks, input int bp);
    logic [20:0] exp_q[$];
    logic [20:0] prev_k = '0;
    logic [20:0] got;
    int idx = 0, cyc = 0, cnt_model = 0, lat_at = -1, done_at = -1, bp_left = 5;
    bit prev_v = 0, prev_hs = 0, hs_out, fin = 0, s0, s1;
    foreach (cand[i])
      for (int e = 0; e < 2; e++)
        if (survives(cand[i], e, ks)) exp_q.push_back(21'((e << 20) | cand[i]));
    @(negedge clk_i);
    stb_i = 1; ks_bit_i = ks; out_ready_i = 0;
    in_valid_i = 1; in_key_i = 20'(cand[0]); in_last_i = (cand.size() == 1);
    while (!fin && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) begin
        check_eq("start_count", count_o, 0);
        check_eq("start_busy", busy_o, 1);
        check_eq("start_in_ready", in_ready_o, 1);
      end
      if (prev_v && !prev_hs) begin
        check_eq("hold_valid", out_valid_o, 1);
        check_eq("hold_key", out_key_o, prev_k);
      end
      if (cyc == lat_at) check_eq("out_latency", out_valid_o, 1);
      if (out_valid_o) check_eq("in_ready_while_out", in_ready_o, 0);
      if (done_o) begin
        check_eq("done_count", count_o, cnt_model);
        check_eq("done_pending", exp_q.size(), 0);
        check_eq("done_consumed", idx, cand.size());
        check_eq("done_busy", busy_o, 0);
        if (done_at >= 0) check_eq("done_latency", cyc, done_at);
        fin = 1;
        stb_i = 0; in_valid_i = 0; out_ready_i = 1;
      end else begin
        check_eq("busy", busy_o, 1);
        ks_bit_i = 1'($urandom);
        stb_i = ($urandom % 8 == 0);
        case (bp)
          1: out_ready_i = 1;
          2: if (out_valid_o && bp_left > 0) begin out_ready_i = 0; bp_left--; end
             else out_ready_i = 1;
          default: out_ready_i = 1'($urandom);
        endcase
        hs_out = out_valid_o && out_ready_i;
        if (hs_out) begin
          if (exp_q.size() == 0) check_eq("extra_output", 1, 0);
          else begin
            got = exp_q.pop_front();
            check_eq("out_key", out_key_o, got);
            cnt_model++;
          end
        end
        prev_v = out_valid_o; prev_hs = hs_out; prev_k = out_key_o;
        if (idx < cand.size()) begin
          in_valid_i = ($urandom % 4 != 0);
          in_key_i = 20'(cand[idx]);
          in_last_i = (idx == cand.size() - 1);
        end else begin
          in_valid_i = 1'($urandom);
          in_key_i = 20'($urandom);
          in_last_i = 1'($urandom);
        end
        if (in_ready_o && in_valid_i) begin
          if (idx >= cand.size()) check_eq("extra_input", 1, 0);
          else begin
            s0 = survives(cand[idx], 0, ks);
            s1 = survives(cand[idx], 1, ks);
            lat_at = s0 ? cyc + 2 : (s1 ? cyc + 3 : -1);
            if (idx == cand.size() - 1 && !s0 && !s1) done_at = cyc + 3;
            idx++;
          end
        end
      end
    end
    if (!fin) check_eq("run_timeout", 0, 1);
    @(negedge clk_i);
    check_eq("done_pulse_width", done_o, 0);
    check_eq("idle_count_hold", count_o, cnt_model);
    check_eq("idle_busy", busy_o, 0);
  endtask

  initial begin
    int n;
    resetn_i = 0;
    repeat (2) @(negedge clk_i);
    check_reset_state("reset");
    resetn_i = 1;

    cand = '{32'h00000};          run_case(0, 1);
    cand = '{32'h00000};          run_case(1, 1);
    cand = '{32'hFFFFF};          run_case(1, 1);
    cand = '{32'hFFFFF};          run_case(0, 1);
    cand = '{32'hFFFFF};          run_case(1, 2);

    // reset while a survivor is waiting in W0
    @(negedge clk_i);
    stb_i = 1; ks_bit_i = 0; in_valid_i = 1; in_key_i = '0; in_last_i = 1; out_ready_i = 0;
    @(negedge clk_i);
    stb_i = 0;
    n = 0;
    while (!out_valid_o && n < 10) begin
      @(negedge clk_i);
      in_valid_i = 0;
      n++;
    end
    check_eq("w0_reached", out_valid_o, 1);
    resetn_i = 0;
    @(negedge clk_i);
    check_reset_state("midrun_reset");
    resetn_i = 1; out_ready_i = 1;
    @(negedge clk_i);
    check_eq("post_reset_no_done", done_o, 0);
    check_eq("post_reset_no_valid", out_valid_o, 0);
    cand = '{32'h00000};          run_case(0, 1);

    for (int r = 0; r < 25; r++) begin
      cand.delete();
      n = 1 + int'($urandom % 8);
      for (int i = 0; i < n; i++) cand.push_back(int'($urandom & 32'hFFFFF));
      run_case(1'($urandom), (r % 3 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crypto1_extend_filter.md
CRYPTO1_EXTEND_FILTER -- requirements
Module: crypto1_extend_filter

Interface
REQ-001 Parameter FA, default 16'h9E98: filter-a truth table; fa(n) = FA[n] for a 4-bit n.
REQ-002 Parameter FB, default 16'hB48E: filter-b truth table; fb(n) = FB[n].
REQ-003 Parameter FC, default 32'hEC57E80A: filter-c truth table; fc(m) = FC[m] for a 5-bit m.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset.
REQ-005 CLK  in  1  clock; all state changes on its rising edge.
REQ-006 RESETn  in  1  synchronous active-low reset.
REQ-007 STB  in  1  start pulse; samples KS_BIT and begins a run.
REQ-008 KS_BIT  in  1  keystream bit the extended candidates must reproduce.
REQ-009 IN_VALID / IN_READY  in / out  1 / 1  candidate-input handshake.
REQ-010 IN_KEY  in  20  20-bit candidate from the enumerator, in the enumerator's bit-reversed output order.
REQ-011 IN_LAST  in  1  qualifies IN_KEY as the final candidate of the run.
REQ-012 OUT_VALID / OUT_READY  out / in  1 / 1  survivor-output handshake.
REQ-013 OUT_KEY  out  21  surviving extended candidate.
REQ-014 BUSY  out  1  high from STB acceptance until DONE.
REQ-015 DONE  out  1  one-cycle pulse after the last candidate is fully processed.
REQ-016 COUNT  out  17  number of survivors emitted in the current or last run.

Function
REQ-017 Filter f(W), W 20 bits: r = bit-reverse of W (r[i] = W[19-i]); c = {fa(r[19:16]), fb(r[15:12]), fa(r[11:8]), fa(r[7:4]), fb(r[3:0])}; f = fc(c).
REQ-018 Extension: for a candidate K and extension bit e, X = {e, K} (21 bits); X survives iff f(X[20:1]) == latched KS_BIT.
REQ-019 FSM states: IDLE, RUN, T0, W0, T1, W1, FIN.
- IDLE: STB -> latch KS_BIT, clear COUNT, BUSY=1 -> RUN.
- RUN: IN_READY=1; a handshake registers IN_KEY and IN_LAST -> T0.
- T0: test e=0; pass -> load OUT_KEY, OUT_VALID=1 -> W0; fail -> T1.
- W0: hold until OUT_VALID&OUT_READY -> T1.
- T1 / W1: same for e=1; exit goes to FIN if the registered last flag is set, else to RUN.
- FIN: DONE=1 for exactly one cycle, BUSY=0 -> IDLE.
REQ-020 IN_READY SHALL be high only in RUN; IN_VALID is ignored in all other states.
REQ-021 OUT_VALID and OUT_KEY SHALL stay stable from assertion until the handshake; OUT_VALID drops the cycle after the handshake.
REQ-022 Latency: input handshake at edge N -> OUT_VALID high after edge N+1 if e=0 survives, or after edge N+2 if only e=1 survives.
REQ-023 Output order per candidate SHALL be e=0 before e=1; candidate order is preserved.
REQ-024 COUNT SHALL increment by 1 on each output handshake; maximum 65536, no wrap.
REQ-025 COUNT SHALL hold its final value in IDLE until the next accepted STB.
REQ-026 STB while BUSY SHALL be ignored; KS_BIT changes mid-run have no effect.
REQ-027 When no candidate survives, a candidate still takes 2 cycles (T0, T1); IN_LAST on such a candidate still yields FIN and DONE.
REQ-028 STB and a valid input in the same IDLE cycle: the input SHALL NOT be accepted until RUN.

Reset
REQ-029 While RESETn=0 at a clock edge:
- state -> IDLE;
- IN_READY, OUT_VALID, BUSY, DONE -> 0;
- COUNT, OUT_KEY, latched KS_BIT and last flag -> 0.
REQ-030 Reset mid-run SHALL abandon the run: no DONE, and any pending output is dropped.

Verification
REQ-031 STB with KS_BIT=0; IN_KEY=0x00000 with IN_LAST=1 -> one output 0x000000; DONE pulse; COUNT=1.
REQ-032 STB with KS_BIT=1; IN_KEY=0x00000 with IN_LAST=1 -> one output 0x100000; COUNT=1.
REQ-033 STB with KS_BIT=1; IN_KEY=0xFFFFF with IN_LAST=1 -> outputs 0x0FFFFF then 0x1FFFFF; COUNT=2.
REQ-034 STB with KS_BIT=0; IN_KEY=0xFFFFF with IN_LAST=1 -> no OUT_VALID; DONE exactly 2 cycles after entering T0; COUNT=0.
REQ-035 Backpressure: hold OUT_READY=0 for 5 cycles during the REQ-033 case -> OUT_KEY stable and IN_READY low throughout; both outputs are still delivered in order.
REQ-036 Assert RESETn=0 while in W0, then run REQ-031 -> no stale output or DONE from before reset; COUNT=1.
